// File: rtl/debounce_botones_if.sv
// debounce_botones_if: raw buttons and PicoBlaze read port in, sticky press flags and debounced levels out.
interface debounce_botones_if;
    logic [3:0] btn_raw;
    logic [7:0] Port_ID;
    logic       read_strobe;
    logic       aumenta;
    logic       disminuye;
    logic       siguiente;
    logic       anterior;
    logic [3:0] btn_estable;

    modport master (
        output btn_raw, Port_ID, read_strobe,
        input  aumenta, disminuye, siguiente, anterior, btn_estable
    );
    modport slave (
        input  btn_raw, Port_ID, read_strobe,
        output aumenta, disminuye, siguiente, anterior, btn_estable
    );
endinterface

// File: rtl/debounce_botones.sv
// debounce_botones: synchronize, debounce and latch four buttons as sticky flags cleared by PicoBlaze port reads;
// bits 0/1 auto-repeat while held.
module debounce_botones #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input logic clk,
    input logic reset,
    debounce_botones_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [3:0] sync_a, sync, estable, flag, press, rep, clr;

    always_ff @(posedge clk or negedge reset)
        if (!reset) {sync, sync_a} <= '0;
        else        {sync, sync_a} <= {sync_a, bus.btn_raw};

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic [DW-1:0] cnt;
        logic          est_q, flag_q;
        assign estable[i] = est_q;
        assign flag[i]    = flag_q;
        // press fires on the same edge the debounced level rises, so flag and level rise together
        assign press[i] = sync[i] & ~est_q & (cnt == DW'(DEBOUNCE_CYCLES - 1));
        assign clr[i]   = bus.read_strobe & (bus.Port_ID == 8'(3 + i));
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                cnt    <= '0;
                est_q  <= 1'b0;
                flag_q <= 1'b0;
            end else begin
                flag_q <= press[i] | rep[i] | (flag_q & ~clr[i]);
                if (sync[i] == est_q) cnt <= '0;
                else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    est_q <= sync[i];
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
            end

        if (i < 2) begin : g_rep
            state_t        state;
            logic [RW-1:0] rcnt;
            assign rep[i] = est_q & ((state == HOLD   && rcnt == RW'(REPEAT_DELAY - 1)) ||
                                     (state == REPEAT && rcnt == RW'(REPEAT_RATE - 1)));
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else if (state == IDLE) begin
                    rcnt <= '0;
                    if (press[i]) state <= HOLD;
                end else if (!est_q) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else if (rep[i]) begin
                    state <= REPEAT;
                    rcnt  <= '0;
                end else rcnt <= rcnt + 1'b1;
        end else begin : g_norep
            assign rep[i] = 1'b0;
        end
    end

    assign bus.aumenta     = flag[0];
    assign bus.disminuye   = flag[1];
    assign bus.siguiente   = flag[2];
    assign bus.anterior    = flag[3];
    assign bus.btn_estable = estable;
endmodule
